// File: rtl/onehot_scoreboard_pkg.sv
// Shared types and helpers for the one-hot busy scoreboard.
// The typedefs are sized for the default SIZE; the top module keeps SIZE at this value.
package onehot_scoreboard_pkg;

  localparam int SB_SIZE  = 3;
  localparam int SB_WIDTH = 1 << SB_SIZE;

  typedef logic [SB_SIZE-1:0] idx_t;
  typedef logic [SB_SIZE:0]   cnt_t;

  function automatic cnt_t popcount(input logic [SB_WIDTH-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < SB_WIDTH; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/onehot_scoreboard_decoder.sv
// Enabled N-to-2^N one-hot decoder: all zeros when en is low.
module onehot_scoreboard_decoder #(
  parameter int SIZE = 3
) (
  input  logic                   en,
  input  logic [SIZE-1:0]        idx,
  output logic [(1<<SIZE)-1:0]   oh
);

  always_comb begin
    oh = '0;
    if (en) begin
      oh[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_scoreboard.sv
// Busy-bitmap scoreboard: set ports mark resources busy, clear ports release them,
// with registered popcount, full/empty status and sticky misuse flags.
module onehot_scoreboard
  import onehot_scoreboard_pkg::*;
#(
  parameter int SIZE      = SB_SIZE,
  parameter int WIDTH     = 1 << SIZE,
  parameter int SET_PORTS = 2,
  parameter int CLR_PORTS = 2,
  parameter int Q_PORTS   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SET_PORTS-1:0]      set_en,
  input  logic [SET_PORTS*SIZE-1:0] set_idx,
  input  logic [CLR_PORTS-1:0]      clr_en,
  input  logic [CLR_PORTS*SIZE-1:0] clr_idx,
  input  logic [Q_PORTS*SIZE-1:0]   q_idx,
  output logic [Q_PORTS-1:0]        q_busy,
  output logic [WIDTH-1:0]          mask,
  output logic [SIZE:0]             count,
  output logic                      full,
  output logic                      empty,
  output logic                      err_dup,
  output logic                      err_clr,
  input  logic                      err_clear
);

  localparam int FULL_W = 1 << SIZE;

  logic [FULL_W-1:0] set_oh  [SET_PORTS];
  logic [FULL_W-1:0] clr_oh  [CLR_PORTS];
  logic [WIDTH-1:0]  set_acc [SET_PORTS+1];
  logic [WIDTH-1:0]  clr_acc [CLR_PORTS+1];
  logic [WIDTH-1:0]  set_all;
  logic [WIDTH-1:0]  clr_all;

  logic [WIDTH-1:0]    mask_next;
  logic [SB_WIDTH-1:0] mask_wide;
  cnt_t                count_next;
  logic                dup_hit;
  logic                clr_hit;

  assign set_acc[0] = '0;
  assign clr_acc[0] = '0;

  // Decoded bits at or above WIDTH are dropped, so out-of-range indices are ignored.
  for (genvar p = 0; p < SET_PORTS; p++) begin : g_set
    onehot_scoreboard_decoder #(.SIZE(SIZE)) u_dec (
      .en  (set_en[p]),
      .idx (set_idx[p*SIZE +: SIZE]),
      .oh  (set_oh[p])
    );
    assign set_acc[p+1] = set_acc[p] | set_oh[p][WIDTH-1:0];
  end

  for (genvar p = 0; p < CLR_PORTS; p++) begin : g_clr
    onehot_scoreboard_decoder #(.SIZE(SIZE)) u_dec (
      .en  (clr_en[p]),
      .idx (clr_idx[p*SIZE +: SIZE]),
      .oh  (clr_oh[p])
    );
    assign clr_acc[p+1] = clr_acc[p] | clr_oh[p][WIDTH-1:0];
  end

  assign set_all = set_acc[SET_PORTS];
  assign clr_all = clr_acc[CLR_PORTS];

  // Set wins over clear on the same bit; a clear masked by a same-cycle set is not stray.
  always_comb begin
    mask_next            = (mask & ~clr_all) | set_all;
    mask_wide            = '0;
    mask_wide[WIDTH-1:0] = mask_next;
    count_next           = popcount(mask_wide);
    dup_hit              = |(set_all & mask);
    clr_hit              = |(clr_all & ~mask & ~set_all);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask    <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      err_dup <= 1'b0;
      err_clr <= 1'b0;
    end else begin
      mask    <= mask_next;
      count   <= count_next;
      full    <= (count_next == cnt_t'(WIDTH));
      empty   <= (count_next == '0);
      err_dup <= dup_hit | (err_dup & ~err_clear);
      err_clr <= clr_hit | (err_clr & ~err_clear);
    end
  end

  for (genvar k = 0; k < Q_PORTS; k++) begin : g_query
    idx_t qi;
    assign qi        = q_idx[k*SIZE +: SIZE];
    assign q_busy[k] = (int'(qi) < WIDTH) ? mask[qi] : 1'b0;
  end

endmodule

// File: doc/onehot_scoreboard.md
# onehot_scoreboard

Multi-port, stateful successor to the N-to-2^N one-hot decoder. Each of several set and clear ports carries a binary index plus enable. Each port is decoded to one-hot and merged into a WIDTH-bit busy bitmap held in registers. The block also tracks population count, full/empty status and duplicate-set/stray-clear errors. It serves as the register/resource scoreboard between issue (set) and writeback (clear) stages.

## Interface
Parameters:
- SIZE, 3, index width in bits
- WIDTH, 1<<SIZE, bitmap width; must be ≤ 1<<SIZE
- SET_PORTS, 2, number of set ports
- CLR_PORTS, 2, number of clear ports
- Q_PORTS, 2, number of query ports

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- set_en  in  SET_PORTS  per-port set request
- set_idx  in  SET_PORTS×SIZE  per-port index to set
- clr_en  in  CLR_PORTS  per-port clear request
- clr_idx  in  CLR_PORTS×SIZE  per-port index to clear
- q_idx  in  Q_PORTS×SIZE  query indices
- q_busy  out  Q_PORTS  mask[q_idx[k]], combinational from the registered mask
- mask  out  WIDTH  registered busy bitmap
- count  out  SIZE+1  registered popcount of mask
- full  out  1  registered; count==WIDTH
- empty  out  1  registered; count==0
- err_dup  out  1  sticky; a set was applied to a bit that was already busy
- err_clr  out  1  sticky; a clear was applied to a bit that was already idle
- err_clear  in  1  clears both sticky error flags

## Operation
- Each port is decoded with the enabled N-to-2^N decoder: set_oh[p] = en ? onehot(idx) : 0.
- SET_ALL = OR of all set_oh. CLR_ALL = OR of all clr_oh.
- Next mask = (mask & ~CLR_ALL) | SET_ALL. If set and clear hit the same bit in the same cycle, the set wins and the bit ends busy.
- Two or more set ports with the same index merge into a single set. This is not a duplicate error unless the bit was already busy.
- Indices ≥ WIDTH, possible only when WIDTH < 1<<SIZE, are ignored. They are not errors.
- err_dup is set when (SET_ALL & mask) != 0, measured against the pre-edge mask.
- err_clr is set when (CLR_ALL & ~mask & ~SET_ALL) != 0.
- Both error flags are sticky until err_clear or reset. If err_clear and a new error occur in the same cycle, the flag ends set.
- count, full and empty are computed from the next mask and registered with it, so they never lag mask.
- q_busy reads the current mask. It does not bypass same-cycle sets or clears.

## Timing
- Reset: while rst_n is low at a clk edge, mask=0, count=0, empty=1, full=0, err_dup=0, err_clr=0. All requests in that cycle are discarded.
- Reset asserted mid-operation returns the block to the reset state on the next edge, regardless of pending sets.
- Set/clear latency is 1 cycle: a request at edge N is visible on mask, count, q_busy, full and empty after edge N.
- The error flags assert 1 cycle after the offending request.
- No handshake: every enabled request is accepted every cycle. There is no backpressure, and setting a bit while full is only an err_dup event.
- The state holds when no enable is active.

## Structure
- Package onehot_scoreboard_pkg holds:
  - the index typedef logic [SIZE-1:0]
  - the count typedef logic [SIZE:0]
  - a popcount function
- Sub-module: the existing enabled one-hot Decoder, instantiated once per set port and once per clear port with SIZE passed through.
- A generate-loop OR-reduction merges the decoder outputs.
- Everything else lives in one always_ff block plus combinational next-state logic.

## Test plan
All scenarios use SIZE=3, WIDTH=8, 2 set ports, 2 clear ports.
- Reset then idle: mask=0x00, count=0, empty=1, full=0, both errors 0.
- Set idx 1 and idx 6 in one cycle: next cycle mask=0x42, count=2, q_busy for idx 6 = 1.
- Fill to full: after 8 distinct sets, full=1. Then clear idx 3: mask=0xF7, count=7, full=0.
- Same cycle, with mask=0x10: set idx 4 and clear idx 4 → mask stays 0x10, err_dup=1, err_clr=0.
- Clear idle idx 2 → err_clr=1. It stays 1 until err_clear pulses, then returns to 0.
- Both set ports target idx 5 on an empty mask: mask=0x20, count=1, err_dup=0.
- rst_n low mid-stream with mask=0xFF → next cycle mask=0, empty=1.
